perf_event_counter_bank: RTL

- Parametrised successor to the fixed four-counter LLC hit/miss logic in the SoC control block.
- Provides NUM_EVENTS independent event counters of CNT_WIDTH bits.
- Features: per-channel enable, wrap or saturate mode, atomic snapshot, preset, sticky overflow flags and a maskable overflow interrupt.
- Sits on the SoC control APB-to-register path as a 32-bit register slave; event pulses come from the LLC and other SoC monitors.

---
 rtl/perf_event_counter_bank.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/perf_event_counter_bank.sv
// rtl/perf_event_counter_bank.sv - bank of NUM_EVENTS event counters with snapshot,
// preset, sticky overflow and maskable interrupt behind a 32-bit register port.
module perf_event_counter_bank #(
  parameter int NUM_EVENTS = 4,
  parameter int CNT_WIDTH  = 48,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o,
  output logic                  ready_o,
  output logic                  error_o,
  input  logic [NUM_EVENTS-1:0] event_i,
  output logic                  irq_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic                  ctrl_en_q, ctrl_en_d, ctrl_sat_q, ctrl_sat_d;
  logic [NUM_EVENTS-1:0] en_mask_q, en_mask_d, ovf_q, ovf_d, irq_en_q, irq_en_d;
  logic [NUM_EVENTS-1:0] ovf_set, ovf_w1c;
  logic [CNT_WIDTH-1:0]  cnt_q [NUM_EVENTS];
  logic [CNT_WIDTH-1:0]  cnt_d [NUM_EVENTS];
  logic [CNT_WIDTH-1:0]  snap_q[NUM_EVENTS];
  logic [CNT_WIDTH-1:0]  snap_d[NUM_EVENTS];
  logic                  ready_q, error_q;
  logic [31:0]           rdata_q;

  logic [31:0] addr_w, rd_word;
  logic [4:0]  ch;
  logic        hi, aligned, ch_ok, is_ctl, is_cnt, is_snap, acc_ok, wr_ok, preset_ok;
  logic        snap_pulse, clr_pulse;
  logic [63:0] cnt_sel, snap_sel, preset64;

  assign addr_w  = 32'(addr_i);
  assign ch      = addr_w[7:3];
  assign hi      = addr_w[2];
  assign aligned = (addr_w[1:0] == 2'b00);
  assign ch_ok   = ({27'b0, ch} < 32'(NUM_EVENTS));
  assign is_ctl  = aligned && (addr_w[31:4] == 28'h0);
  assign is_cnt  = aligned && (addr_w[31:8] == 24'h1) && ch_ok;
  assign is_snap = aligned && (addr_w[31:8] == 24'h2) && ch_ok && !we_i;
  assign acc_ok  = is_ctl || is_cnt || is_snap;
  assign wr_ok   = req_i && we_i && acc_ok;
  // High-word presets only exist when the counter actually has bits above 31.
  assign preset_ok = !hi || (CNT_WIDTH > 32);

  always_comb begin
    cnt_sel  = '0;
    snap_sel = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (ch == 5'(i)) begin
        cnt_sel  = 64'(cnt_q[i]);
        snap_sel = 64'(snap_q[i]);
      end
    end
  end

  assign preset64 = hi ? {wdata_i, cnt_sel[31:0]} : {cnt_sel[63:32], wdata_i};

  always_comb begin
    rd_word = '0;
    if (is_ctl) begin
      case (addr_w[3:2])
        2'd0: rd_word = {30'b0, ctrl_sat_q, ctrl_en_q};
        2'd1: rd_word = 32'(en_mask_q);
        2'd2: rd_word = 32'(ovf_q);
        2'd3: rd_word = 32'(irq_en_q);
      endcase
    end else if (is_cnt) begin
      rd_word = hi ? cnt_sel[63:32] : cnt_sel[31:0];
    end else if (is_snap) begin
      rd_word = hi ? snap_sel[63:32] : snap_sel[31:0];
    end
  end

  always_comb begin
    ctrl_en_d  = ctrl_en_q;
    ctrl_sat_d = ctrl_sat_q;
    en_mask_d  = en_mask_q;
    irq_en_d   = irq_en_q;
    ovf_w1c    = '0;
    ovf_set    = '0;
    snap_pulse = 1'b0;
    clr_pulse  = 1'b0;
    if (wr_ok && is_ctl) begin
      case (addr_w[3:2])
        2'd0: begin
          ctrl_en_d  = wdata_i[0];
          ctrl_sat_d = wdata_i[1];
          snap_pulse = wdata_i[2];
          clr_pulse  = wdata_i[3];
        end
        2'd1: en_mask_d = wdata_i[NUM_EVENTS-1:0];
        2'd2: ovf_w1c   = wdata_i[NUM_EVENTS-1:0];
        2'd3: irq_en_d  = wdata_i[NUM_EVENTS-1:0];
      endcase
    end
    // Per counter: clear beats preset beats event; snapshot always sees the current q.
    for (int i = 0; i < NUM_EVENTS; i++) begin
      snap_d[i] = snap_pulse ? cnt_q[i] : snap_q[i];
      cnt_d[i]  = cnt_q[i];
      if (clr_pulse) begin
        cnt_d[i] = '0;
      end else if (wr_ok && is_cnt && preset_ok && (ch == 5'(i))) begin
        cnt_d[i] = preset64[CNT_WIDTH-1:0];
      end else if (event_i[i] && en_mask_q[i] && ctrl_en_q) begin
        if (cnt_q[i] == CNT_MAX) begin
          ovf_set[i] = 1'b1;
          cnt_d[i]   = ctrl_sat_q ? CNT_MAX : '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
    ovf_d = (ovf_q & ~ovf_w1c) | ovf_set;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_en_q  <= 1'b0;
      ctrl_sat_q <= 1'b0;
      en_mask_q  <= '0;
      ovf_q      <= '0;
      irq_en_q   <= '0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      rdata_q    <= '0;
      for (int i = 0; i < NUM_EVENTS; i++) begin
        cnt_q[i]  <= '0;
        snap_q[i] <= '0;
      end
    end else begin
      ctrl_en_q  <= ctrl_en_d;
      ctrl_sat_q <= ctrl_sat_d;
      en_mask_q  <= en_mask_d;
      ovf_q      <= ovf_d;
      irq_en_q   <= irq_en_d;
      ready_q    <= req_i;
      error_q    <= req_i && !acc_ok;
      rdata_q    <= (req_i && !we_i && acc_ok) ? rd_word : 32'h0;
      for (int i = 0; i < NUM_EVENTS; i++) begin
        cnt_q[i]  <= cnt_d[i];
        snap_q[i] <= snap_d[i];
      end
    end
  end

  // A reset arriving while a response is pending suppresses that response.
  assign ready_o = ready_q && !rst_i;
  assign error_o = error_q;
  assign rdata_o = rdata_q;
  assign irq_o   = |(ovf_q & irq_en_q);

endmodule
